axi4_lite_slave_regs: RTL and testbench
=======================================

# axi4_lite_slave_regs

AXI4-Lite responder (slave end of the bus) that exposes a bank of NUM_REGS read/write 32-bit registers to a bus master. It accepts write address and write data independently, commits the write, returns a write response, and serves reads with registered data. It is the memory-mapped endpoint that the team's AXI4-Lite master and testbench drive over the axi4_lite bus signals.

## Interface
- Addr_Width, default from axi4_lite_Defs (32): address width.
- Data_Width, default from axi4_lite_Defs (32): data width and register width.
- NUM_REGS, default 16: number of registers, power of two, 2..256.

Ports:
- ACLK  in  1  system clock, all state on rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- AWADDR  in  Addr_Width  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  Data_Width  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BVALID  out  1  write response valid.
- BREADY  in  1  master accepts write response.
- ARADDR  in  Addr_Width  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  Data_Width  read data.
- RVALID  out  1  read data valid.
- RREADY  in  1  master accepts read data.

## Operation
- Byte addressing, word-aligned: index = ADDR >> 2; ADDR[1:0] ignored. Index >= NUM_REGS is out of range.
- No response codes on this bus: out-of-range writes are silently dropped; out-of-range reads return 0.
- Write FSM, states W_IDLE, W_RESP. In W_IDLE, AW and W are captured independently; an aw_done / w_done flag is set per channel at its handshake, and that channel's READY drops once captured. When both are captured (same or different cycles), the register is written and BVALID is set on the same edge; state becomes W_RESP. In W_RESP, AWREADY = WREADY = 0; BVALID holds until BVALID & BREADY, then W_IDLE, flags cleared.
- Read FSM, states R_IDLE, R_DATA. In R_IDLE, ARREADY = 1; on ARVALID & ARREADY, RDATA is loaded from the addressed register, RVALID = 1, ARREADY = 0, state R_DATA. RDATA holds stable until RVALID & RREADY, then R_IDLE.
- Read and write channels are fully independent; one outstanding transaction per direction.
- Same-edge collision (read capture and write commit to the same index): read returns the pre-write value.

## Timing
- Reset (asynchronous, immediate): all outputs 0, all registers 0, both FSMs idle, flags cleared. AWREADY, WREADY, ARREADY rise on the first ACLK edge after ARESET deasserts. Reset during a transaction abandons it; an uncommitted write is never committed.
- READY outputs are registered.
- Write latency: BVALID is high in the cycle after the later of the AW and W handshakes. Written data is visible to a read captured one edge later.
- Read latency: RVALID is high in the cycle after the AR handshake.
- Minimum throughput: one write per 2 cycles (AW+W, B accepted immediately), one read per 2 cycles.
- VALID/data outputs never drop without a handshake, except on reset.

## Structure
- Package axi4_lite_Defs: Addr_Width, Data_Width, NUM_REGS default, typedef enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- Sub-module axi4_lite_regfile: NUM_REGS x Data_Width array, one write port, one registered read port, asynchronous active-high clear. The top holds both FSMs, the capture registers and the address decode.

## Test plan
- Reset release: all outputs 0 during ARESET; AWREADY/WREADY/ARREADY = 1 one edge after release; a read of 0x0 returns 0.
- AW and W in the same cycle, AWADDR = 0x8, WDATA = 0xDEADBEEF, BREADY = 1 -> BVALID the next cycle for one cycle; a subsequent read of 0x8 returns 0xDEADBEEF.
- W 3 cycles before AW (0x4, 0x12345678): WREADY drops after W, no BVALID until AW; BVALID the cycle after AW; readback correct.
- Backpressure: BREADY = 0 for 5 cycles -> BVALID held, AWREADY/WREADY stay 0; RREADY = 0 for 4 cycles -> RVALID and RDATA stable.
- Out of range: write 0xCAFEF00D to 0x40 (NUM_REGS = 16) -> BVALID still issued, no register changed; read 0x40 -> 0.
- Collision and reset: read capture of 0xC on the same edge as a commit of 0x55 to 0xC -> old value returned, next read returns 0x55. ARESET asserted mid-W_RESP -> BVALID drops immediately, registers cleared.

Source files
------------

// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared defaults and FSM state types for the AXI4-Lite register responder.
package axi4_lite_Defs;

  localparam int unsigned Addr_Width = 32;
  localparam int unsigned Data_Width = 32;
  localparam int unsigned NUM_REGS   = 16;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register array with one write port and one registered read port.
// Asynchronous active-high clear empties the array and the read register.
module axi4_lite_regfile #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned Data_Width = 32,
  localparam int unsigned IdxW      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IdxW-1:0]       waddr,
  input  logic [Data_Width-1:0] wdata,
  input  logic                  re,
  input  logic                  rzero,
  input  logic [IdxW-1:0]       raddr,
  output logic [Data_Width-1:0] rdata
);

  logic [Data_Width-1:0] mem [NUM_REGS];

  // Storage: commit a write on we, clear everything on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: loads only on re, so data stays stable while the master stalls.
  // A same-edge write is not yet visible here, so the pre-write value is returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS read/write registers.
// Write and read paths are independent FSMs; all handshake outputs are registered.
module axi4_lite_slave_regs
  import axi4_lite_Defs::*;
#(
  parameter int unsigned Addr_Width = axi4_lite_Defs::Addr_Width,
  parameter int unsigned Data_Width = axi4_lite_Defs::Data_Width,
  parameter int unsigned NUM_REGS   = axi4_lite_Defs::NUM_REGS
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [Addr_Width-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [Data_Width-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [Addr_Width-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [Data_Width-1:0] RDATA,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);
  localparam logic [Addr_Width-1:0] NumRegsAddr = Addr_Width'(NUM_REGS);

  // ---------------------------------------------------------------- write path
  wr_state_t             wr_state, wr_state_next;
  logic                  aw_done, aw_done_next;
  logic                  w_done, w_done_next;
  logic [Addr_Width-1:0] aw_addr, aw_addr_next;
  logic [Data_Width-1:0] w_data, w_data_next;
  logic                  awready_next, wready_next, bvalid_next;

  logic                  aw_hs, w_hs, aw_have, w_have, wr_commit, wr_in_range;
  logic [Addr_Width-1:0] commit_addr;
  logic [Data_Width-1:0] commit_data;

  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign aw_have = aw_done | aw_hs;
  assign w_have  = w_done | w_hs;

  // Commit as soon as both halves are in hand, bypassing the capture regs on the
  // handshake edge so same-cycle AW+W needs no extra cycle.
  assign wr_commit   = (wr_state == W_IDLE) & aw_have & w_have;
  assign commit_addr = aw_hs ? AWADDR : aw_addr;
  assign commit_data = w_hs ? WDATA : w_data;
  assign wr_in_range = (commit_addr >> 2) < NumRegsAddr;

  // Write state, capture flags/registers and registered handshake outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
    end else begin
      wr_state <= wr_state_next;
      aw_done  <= aw_done_next;
      w_done   <= w_done_next;
      aw_addr  <= aw_addr_next;
      w_data   <= w_data_next;
      AWREADY  <= awready_next;
      WREADY   <= wready_next;
      BVALID   <= bvalid_next;
    end
  end

  // Write next-state: independent AW/W capture, commit, then wait for B handshake.
  always_comb begin
    wr_state_next = wr_state;
    aw_done_next  = aw_done;
    w_done_next   = w_done;
    aw_addr_next  = aw_addr;
    w_data_next   = w_data;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs) aw_addr_next = AWADDR;
        if (w_hs)  w_data_next  = WDATA;
        if (wr_commit) begin
          wr_state_next = W_RESP;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
        end else begin
          aw_done_next = aw_have;
          w_done_next  = w_have;
        end
      end
      W_RESP: begin
        if (BVALID & BREADY) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  // Write outputs for the next cycle, derived from the next state.
  always_comb begin
    awready_next = (wr_state_next == W_IDLE) & ~aw_done_next;
    wready_next  = (wr_state_next == W_IDLE) & ~w_done_next;
    bvalid_next  = (wr_state_next == W_RESP);
  end

  // ----------------------------------------------------------------- read path
  rd_state_t rd_state, rd_state_next;
  logic      arready_next, rvalid_next;
  logic      ar_hs, rd_in_range;

  assign ar_hs       = ARVALID & ARREADY;
  assign rd_in_range = (ARADDR >> 2) < NumRegsAddr;

  // Read state and registered handshake outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state <= R_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
    end else begin
      rd_state <= rd_state_next;
      ARREADY  <= arready_next;
      RVALID   <= rvalid_next;
    end
  end

  // Read next-state: capture address, then hold data until R handshake.
  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
      R_DATA:  if (RVALID & RREADY) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Read outputs for the next cycle, derived from the next state.
  always_comb begin
    arready_next = (rd_state_next == R_IDLE);
    rvalid_next  = (rd_state_next == R_DATA);
  end

  // ------------------------------------------------------------------ storage
  axi4_lite_regfile #(
    .NUM_REGS   (NUM_REGS),
    .Data_Width (Data_Width)
  ) u_regfile (
    .clk   (ACLK),
    .rst   (ARESET),
    .we    (wr_commit & wr_in_range),
    .waddr (commit_addr[IdxW+1:2]),
    .wdata (commit_data),
    .re    (ar_hs),
    .rzero (~rd_in_range),
    .raddr (ARADDR[IdxW+1:2]),
    .rdata (RDATA)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed self-checking bench for axi4_lite_slave_regs.
module tb_axi4_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [31:0] RDATA;

  int checks = 0;
  int failures = 0;

  axi4_lite_slave_regs dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // {AWREADY, WREADY, BVALID, ARREADY, RVALID}
  function automatic logic [31:0] hs_bits();
    return {27'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while (!(AWREADY && WREADY) && n < 20) begin
      tick();
      n++;
    end
    check_eq("wr_ready", {30'd0, AWREADY, WREADY}, 32'd3);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("wr_bvalid", {31'd0, BVALID}, 32'd1);
    tick();
    BREADY = 1'b0;
    check_eq("wr_bdone", {31'd0, BVALID}, 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n = 0;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
    while (!ARREADY && n < 20) begin
      tick();
      n++;
    end
    check_eq("rd_ready", {31'd0, ARREADY}, 32'd1);
    tick();
    ARVALID = 1'b0;
    check_eq("rd_rvalid", {31'd0, RVALID}, 32'd1);
    data = RDATA;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check_eq("rd_done", {31'd0, RVALID}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    ARESET = 1'b1;
    AWADDR = '0; WDATA = '0; ARADDR = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state and release
    tick(); tick();
    check_eq("rst_hs", hs_bits(), 32'h00);
    check_eq("rst_rdata", RDATA, 32'h0);
    ARESET = 1'b0;
    #2;
    check_eq("rel_pre", hs_bits(), 32'h00);
    tick();
    check_eq("rel_ready", hs_bits(), 32'h1A);
    axi_read(32'h0, rd);
    check_eq("rd0_init", rd, 32'h0);

    // AW and W in the same cycle
    AWADDR = 32'h8; WDATA = 32'hDEADBEEF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("same_b1", hs_bits(), 32'h06);
    tick();
    check_eq("same_b2", hs_bits(), 32'h1A);
    BREADY = 1'b0;
    axi_read(32'h8, rd);
    check_eq("same_rd", rd, 32'hDEADBEEF);

    // W three cycles before AW
    WDATA = 32'h12345678; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    WVALID = 1'b0;
    check_eq("wfirst_0", hs_bits(), 32'h12);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("wfirst_wait", hs_bits(), 32'h12);
    end
    AWADDR = 32'h4; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check_eq("wfirst_b", hs_bits(), 32'h06);
    tick();
    check_eq("wfirst_idle", hs_bits(), 32'h1A);
    BREADY = 1'b0;
    axi_read(32'h4, rd);
    check_eq("wfirst_rd", rd, 32'h12345678);

    // B backpressure
    AWADDR = 32'h10; WDATA = 32'hA5A5A5A5; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_b_hold", hs_bits(), 32'h06);
      tick();
    end
    check_eq("bp_b_hold5", hs_bits(), 32'h06);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check_eq("bp_b_rel", hs_bits(), 32'h1A);

    // R backpressure
    ARADDR = 32'h10; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_r_valid", hs_bits(), 32'h19);
      check_eq("bp_r_data", RDATA, 32'hA5A5A5A5);
      tick();
    end
    check_eq("bp_r_data4", RDATA, 32'hA5A5A5A5);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check_eq("bp_r_rel", hs_bits(), 32'h1A);

    // Out of range: 0x40 aliases index 0 if the range check is missing
    axi_write(32'h0, 32'h11111111);
    axi_write(32'h40, 32'hCAFEF00D);
    axi_read(32'h0, rd);
    check_eq("oor_reg0", rd, 32'h11111111);
    axi_read(32'h40, rd);
    check_eq("oor_rd", rd, 32'h0);
    axi_read(32'h8, rd);
    check_eq("oor_reg8", rd, 32'hDEADBEEF);

    // Same-edge read capture and write commit to 0xC
    AWADDR = 32'hC; WDATA = 32'h55; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'hC; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check_eq("coll_hs", hs_bits(), 32'h05);
    check_eq("coll_old", RDATA, 32'h0);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    axi_read(32'hC, rd);
    check_eq("coll_new", rd, 32'h55);

    // Reset in the middle of W_RESP
    AWADDR = 32'h14; WDATA = 32'h77; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("mid_b", {31'd0, BVALID}, 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    check_eq("mid_rst_hs", hs_bits(), 32'h00);
    #2;
    ARESET = 1'b0;
    tick();
    check_eq("mid_rel", hs_bits(), 32'h1A);
    axi_read(32'h8, rd);
    check_eq("mid_reg8", rd, 32'h0);
    axi_read(32'h14, rd);
    check_eq("mid_reg14", rd, 32'h0);
    axi_read(32'hC, rd);
    check_eq("mid_regC", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
